// File: rtl/conv_mul_share_arbiter_if.sv
// Requester/consumer bundle for the shared multiplier arbiter.
// The requester side (operand lanes plus result consumer) uses the master modport,
// the arbiter itself uses the slave modport.
interface conv_mul_share_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 24,
    parameter int TAG_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*din0_WIDTH-1:0] req_din0;
    logic [NUM_REQ*din1_WIDTH-1:0] req_din1;
    logic                          rsp_valid;
    logic [TAG_W-1:0]              rsp_tag;
    logic [dout_WIDTH-1:0]         rsp_dout;
    logic                          busy;

    modport master (
        output req_valid,
        output req_din0,
        output req_din1,
        input  req_ready,
        input  rsp_valid,
        input  rsp_tag,
        input  rsp_dout,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_din0,
        input  req_din1,
        output req_ready,
        output rsp_valid,
        output rsp_tag,
        output rsp_dout,
        output busy
    );

endinterface

// File: rtl/conv_mul_share_arbiter.sv
// Round-robin arbiter time-sharing one signed din0 x din1 multiplier pipeline among
// NUM_REQ requesters. A granted operand pair enters stage 1; each ce=1 cycle advances
// every stage, and the tagged product leaves the last stage NUM_STAGE cycles later.
// Stage 1 holds the raw operands; the multiply sits between stage 1 and stage 2 so the
// arbitration mux and the multiplier are not in the same cycle. With a single stage the
// product is formed combinationally from the stage-1 operands.
module conv_mul_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int NUM_STAGE  = 2,
    parameter int din0_WIDTH = 16,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 24
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ce,
    conv_mul_share_arbiter_if.slave bus
);

    localparam int TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PROD_W = din0_WIDTH + din1_WIDTH;

    logic [TAG_W-1:0]              r_rr_ptr;
    logic [NUM_REQ-1:0]            w_grant;
    logic                          w_found;
    logic [TAG_W-1:0]              w_grant_idx;
    int                            w_idx;

    logic signed [din0_WIDTH-1:0]  w_sel_a;
    logic signed [din1_WIDTH-1:0]  w_sel_b;

    logic [NUM_STAGE-1:0]          r_vld;
    logic [TAG_W-1:0]              r_tag [NUM_STAGE];
    logic signed [din0_WIDTH-1:0]  r_a;
    logic signed [din1_WIDTH-1:0]  r_b;

    logic signed [PROD_W-1:0]      w_full;
    logic [dout_WIDTH-1:0]         w_prod;

    // Round-robin search starting at r_rr_ptr; the index wraps explicitly so a
    // non-power-of-two NUM_REQ never produces an out-of-range grant.
    always_comb begin
        w_grant     = '0;
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_idx       = 0;
        if (ce && !ap_rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_idx = int'(r_rr_ptr) + k;
                if (w_idx >= NUM_REQ) begin
                    w_idx = w_idx - NUM_REQ;
                end
                if (!w_found && bus.req_valid[w_idx]) begin
                    w_found        = 1'b1;
                    w_grant_idx    = TAG_W'(w_idx);
                    w_grant[w_idx] = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = w_grant;

    // Operand mux for the granted lane (don't-care when nothing is granted).
    assign w_sel_a = $signed(bus.req_din0[int'(w_grant_idx)*din0_WIDTH +: din0_WIDTH]);
    assign w_sel_b = $signed(bus.req_din1[int'(w_grant_idx)*din1_WIDTH +: din1_WIDTH]);

    // Full-precision signed product of the stage-1 operands, then sized to dout_WIDTH
    // (sign-extends when wider, keeps the low bits when narrower).
    assign w_full = PROD_W'(r_a) * PROD_W'(r_b);
    assign w_prod = dout_WIDTH'(w_full);

    // Pointer moves just past the lane that transferred; otherwise it holds.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_rr_ptr <= '0;
        end else if (ce && w_found) begin
            if (int'(w_grant_idx) == NUM_REQ - 1) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_grant_idx + 1'b1;
            end
        end
    end

    // Stage 1 captures operands and tag only on a transfer so bubbles never disturb them.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (ce && w_found) begin
            r_a <= w_sel_a;
            r_b <= w_sel_b;
        end
    end

    // Valid bits shift every enabled cycle; tags follow only behind a valid bit so the
    // output tag keeps its last value across gaps.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_vld <= '0;
            for (int s = 0; s < NUM_STAGE; s++) begin
                r_tag[s] <= '0;
            end
        end else if (ce) begin
            r_vld[0] <= w_found;
            if (w_found) begin
                r_tag[0] <= w_grant_idx;
            end
            for (int s = 1; s < NUM_STAGE; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_tag[s] <= r_tag[s-1];
                end
            end
        end
    end

    generate
        if (NUM_STAGE == 1) begin : g_single
            assign bus.rsp_dout = w_prod;
        end else begin : g_deep
            logic [dout_WIDTH-1:0] r_prod [1:NUM_STAGE-1];

            // Product stages behind stage 1; data moves only with a valid bit.
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    for (int s = 1; s < NUM_STAGE; s++) begin
                        r_prod[s] <= '0;
                    end
                end else if (ce) begin
                    if (r_vld[0]) begin
                        r_prod[1] <= w_prod;
                    end
                    for (int s = 2; s < NUM_STAGE; s++) begin
                        if (r_vld[s-1]) begin
                            r_prod[s] <= r_prod[s-1];
                        end
                    end
                end
            end

            assign bus.rsp_dout = r_prod[NUM_STAGE-1];
        end
    endgenerate

    assign bus.rsp_valid = r_vld[NUM_STAGE-1];
    assign bus.rsp_tag   = r_tag[NUM_STAGE-1];
    assign bus.busy      = |r_vld;

endmodule
